// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Instruction-memory request/ack bus, fetched-instruction
//                valid/ready bus and branch-redirect inputs of the fetch stage.
//                master = fetch stage side, slave = memory/consumer side.
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int ADDR_WIDTH    = 64,
    parameter int INSTR_WIDTH   = 32,
    parameter int ROM_ADDR_BITS = 16
);
    // instruction memory side
    logic                     rom_req;
    logic [ROM_ADDR_BITS-1:0] rom_addr;
    logic                     rom_ack;
    logic [INSTR_WIDTH-1:0]   rom_data;

    // consumer side
    logic                     instr_valid;
    logic                     instr_ready;
    logic [INSTR_WIDTH-1:0]   instr;
    logic [ADDR_WIDTH-1:0]    instr_pc;
    logic [ADDR_WIDTH-1:0]    instr_pc4;

    // branch redirect
    logic                     redirect_valid;
    logic [ADDR_WIDTH-1:0]    redirect_pc;

    modport master (
        output rom_req,
        output rom_addr,
        input  rom_ack,
        input  rom_data,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc,
        output instr_pc4,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  rom_req,
        input  rom_addr,
        output rom_ack,
        output rom_data,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc,
        input  instr_pc4,
        output redirect_valid,
        output redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Owns the fetch PC, issues word
//                fetches over a req/ack handshake to a variable-latency
//                instruction memory, buffers {instr, pc} in a prefetch FIFO
//                and hands them out over valid/ready. Branch redirects flush
//                the FIFO and restart fetching at the (word-aligned) target.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter int                    ADDR_WIDTH    = 64,
    parameter int                    INSTR_WIDTH   = 32,
    parameter int                    ROM_ADDR_BITS = 16,   // needs ADDR_WIDTH >= ROM_ADDR_BITS + 2
    parameter int                    FIFO_DEPTH    = 4,    // power of two, >= 2
    parameter logic [ADDR_WIDTH-1:0] RESET_PC      = '0    // bits [1:0] must be 0
) (
    input  logic         clock,
    input  logic         reset,
    fetch_unit_if.master bus
);

    localparam int C_PTR_W = $clog2(FIFO_DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;

    // occupancy compared one bit wider so count + push never overflows
    localparam logic [C_CNT_W:0] C_DEPTH = (C_CNT_W + 1)'(FIFO_DEPTH);

    // FETCH   : normal operation, acked data is pushed
    // DISCARD : a redirect arrived while a request was outstanding; that
    //           request must still complete but its data is dropped
    localparam logic [0:0] C_FETCH   = 1'b0;
    localparam logic [0:0] C_DISCARD = 1'b1;

    // ------------------------------------------------------------------
    // state
    // ------------------------------------------------------------------
    logic [0:0]               r_state;
    logic [ADDR_WIDTH-1:0]    r_pc;        // PC of the outstanding / next request
    logic                     r_req;
    logic [ROM_ADDR_BITS-1:0] r_addr;

    logic [C_CNT_W-1:0]       r_count;
    logic [C_PTR_W-1:0]       r_wr_ptr;
    logic [C_PTR_W-1:0]       r_rd_ptr;
    logic [INSTR_WIDTH-1:0]   r_instr_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]    r_pc_mem    [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // handshake decode
    // ------------------------------------------------------------------
    logic                     w_ack;
    logic                     w_valid;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_redirect;
    logic [ADDR_WIDTH-1:0]    w_target;
    logic [ADDR_WIDTH-1:0]    w_pc_inc;
    logic [C_CNT_W:0]         w_occ;

    assign w_ack      = r_req & bus.rom_ack;
    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid & bus.instr_ready;
    assign w_redirect = bus.redirect_valid;

    // misaligned redirect targets are silently word-aligned
    assign w_target   = bus.redirect_pc & ~ADDR_WIDTH'(3);
    assign w_pc_inc   = r_pc + ADDR_WIDTH'(4);

    // a redirect drops the data of any ack on the same edge
    assign w_push     = w_ack & (r_state == C_FETCH) & ~w_redirect;

    // occupancy after this edge, used to decide whether to keep fetching
    assign w_occ      = {1'b0, r_count} + (C_CNT_W + 1)'(w_push) - (C_CNT_W + 1)'(w_pop);

    // ------------------------------------------------------------------
    // next-state logic for the fetch controller
    // ------------------------------------------------------------------
    logic [0:0]               w_state_n;
    logic [ADDR_WIDTH-1:0]    w_pc_n;
    logic                     w_req_n;
    logic [ROM_ADDR_BITS-1:0] w_addr_n;

    // Redirect has top priority; an unacked request is never withdrawn or
    // re-addressed, so a redirect during one parks in DISCARD until its ack.
    always_comb begin
        w_state_n = r_state;
        w_pc_n    = r_pc;
        w_req_n   = r_req;
        w_addr_n  = r_addr;

        if (w_redirect) begin
            w_pc_n = w_target;
            if (r_req && !bus.rom_ack) begin
                w_state_n = C_DISCARD;
            end else begin
                // FIFO is empty after the flush, so there is always space
                w_state_n = C_FETCH;
                w_req_n   = 1'b1;
                w_addr_n  = w_target[ROM_ADDR_BITS+1:2];
            end
        end else if (r_state == C_DISCARD) begin
            if (w_ack) begin
                // stale data dropped; FIFO was flushed so the target fetch
                // can be issued right away
                w_state_n = C_FETCH;
                w_req_n   = 1'b1;
                w_addr_n  = r_pc[ROM_ADDR_BITS+1:2];
            end
        end else begin
            if (w_push) begin
                w_pc_n   = w_pc_inc;
                w_addr_n = w_pc_inc[ROM_ADDR_BITS+1:2];
            end else begin
                w_addr_n = r_pc[ROM_ADDR_BITS+1:2];
            end
            // keep an unacked request up; otherwise request only with space
            w_req_n = (r_req && !bus.rom_ack) || (w_occ < C_DEPTH);
        end
    end

    // fetch controller registers; reset abandons any outstanding request
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= C_FETCH;
            r_pc    <= RESET_PC;
            r_req   <= 1'b0;
            r_addr  <= RESET_PC[ROM_ADDR_BITS+1:2];
        end else begin
            r_state <= w_state_n;
            r_pc    <= w_pc_n;
            r_req   <= w_req_n;
            r_addr  <= w_addr_n;
        end
    end

    // ------------------------------------------------------------------
    // prefetch FIFO
    // ------------------------------------------------------------------

    // pointers and occupancy; a redirect flushes and wins over push/pop
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (w_redirect) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            end
            r_count <= r_count + C_CNT_W'(w_push) - C_CNT_W'(w_pop);
        end
    end

    // entry storage; contents are don't-care until written, so no reset
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= bus.rom_data;
            r_pc_mem[r_wr_ptr]    <= r_pc;
        end
    end

    // ------------------------------------------------------------------
    // outputs
    // ------------------------------------------------------------------
    assign bus.rom_req     = r_req;
    assign bus.rom_addr    = r_addr;
    assign bus.instr_valid = w_valid;
    assign bus.instr       = r_instr_mem[r_rd_ptr];
    assign bus.instr_pc    = r_pc_mem[r_rd_ptr];
    assign bus.instr_pc4   = r_pc_mem[r_rd_ptr] + ADDR_WIDTH'(4);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit. Instance A uses
//                the default 64-bit configuration; instance B uses an 8-bit
//                PC starting at 0xFC to exercise wrap-around and reset during
//                an outstanding request. Memory returns a tag plus the word
//                address so each instruction identifies its own PC.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_a, reset_b;
    logic        ack_a, rdy_a, redir_a;
    logic [63:0] rpc_a;
    logic        ack_b, rdy_b, redir_b;
    logic [7:0]  rpc_b;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- instance A: defaults ----------------
    fetch_unit_if #(.ADDR_WIDTH(64), .INSTR_WIDTH(32), .ROM_ADDR_BITS(16)) bus_a ();

    assign bus_a.rom_ack        = ack_a;
    assign bus_a.rom_data       = {16'hC0DE, bus_a.rom_addr};
    assign bus_a.instr_ready    = rdy_a;
    assign bus_a.redirect_valid = redir_a;
    assign bus_a.redirect_pc    = rpc_a;

    fetch_unit #(
        .ADDR_WIDTH   (64),
        .INSTR_WIDTH  (32),
        .ROM_ADDR_BITS(16),
        .FIFO_DEPTH   (4),
        .RESET_PC     (64'h0)
    ) dut_a (
        .clock(clock),
        .reset(reset_a),
        .bus  (bus_a)
    );

    // ---------------- instance B: 8-bit PC ----------------
    fetch_unit_if #(.ADDR_WIDTH(8), .INSTR_WIDTH(32), .ROM_ADDR_BITS(6)) bus_b ();

    assign bus_b.rom_ack        = ack_b;
    assign bus_b.rom_data       = {26'h0, bus_b.rom_addr};
    assign bus_b.instr_ready    = rdy_b;
    assign bus_b.redirect_valid = redir_b;
    assign bus_b.redirect_pc    = rpc_b;

    fetch_unit #(
        .ADDR_WIDTH   (8),
        .INSTR_WIDTH  (32),
        .ROM_ADDR_BITS(6),
        .FIFO_DEPTH   (4),
        .RESET_PC     (8'hFC)
    ) dut_b (
        .clock(clock),
        .reset(reset_b),
        .bus  (bus_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_a = 1'b1; reset_b = 1'b1;
        ack_a = 1'b0; rdy_a = 1'b0; redir_a = 1'b0; rpc_a = '0;
        ack_b = 1'b0; rdy_b = 1'b0; redir_b = 1'b0; rpc_b = '0;

        // ---- reset values ----
        repeat (3) tick();
        check_eq("rst_req",   bus_a.rom_req,     1'b0);
        check_eq("rst_valid", bus_a.instr_valid, 1'b0);
        check_eq("rst_addr",  bus_a.rom_addr,    16'h0);
        reset_a = 1'b0;

        tick();
        check_eq("first_req",   bus_a.rom_req,     1'b1);
        check_eq("first_addr",  bus_a.rom_addr,    16'h0);
        check_eq("first_valid", bus_a.instr_valid, 1'b0);

        // ---- streaming: one instruction per cycle ----
        ack_a = 1'b1; rdy_a = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check_eq("stream_valid", bus_a.instr_valid, 1'b1);
            check_eq("stream_pc",    bus_a.instr_pc,    64'(4 * (k - 1)));
            check_eq("stream_pc4",   bus_a.instr_pc4,   64'(4 * k));
            check_eq("stream_instr", bus_a.instr,       {16'hC0DE, 16'(k - 1)});
            check_eq("stream_addr",  bus_a.rom_addr,    16'(k));
        end

        // ---- backpressure: head pc 20 held, 24/28/32 fill the FIFO ----
        rdy_a = 1'b0;
        for (int b = 1; b <= 10; b++) begin
            tick();
            check_eq("bp_req",  bus_a.rom_req,  (b < 3) ? 1'b1 : 1'b0);
            check_eq("bp_head", bus_a.instr_pc, 64'd20);
        end

        rdy_a = 1'b1;
        for (int p = 1; p <= 5; p++) begin
            tick();
            check_eq("drain_valid", bus_a.instr_valid, 1'b1);
            check_eq("drain_pc",    bus_a.instr_pc,    64'(20 + 4 * p));
            if (p == 1) check_eq("drain_refetch_addr", bus_a.rom_addr, 16'd9);
        end

        // ---- refill, then redirect with a full FIFO ----
        rdy_a = 1'b0;
        tick();
        check_eq("full_req",  bus_a.rom_req,  1'b0);
        check_eq("full_head", bus_a.instr_pc, 64'd40);

        redir_a = 1'b1; rpc_a = 64'h100;
        tick();
        check_eq("redir_valid", bus_a.instr_valid, 1'b0);
        check_eq("redir_req",   bus_a.rom_req,     1'b1);
        check_eq("redir_addr",  bus_a.rom_addr,    16'h40);

        redir_a = 1'b0; rdy_a = 1'b1;
        tick();
        check_eq("redir_first_valid", bus_a.instr_valid, 1'b1);
        check_eq("redir_first_pc",    bus_a.instr_pc,    64'h100);
        check_eq("redir_first_instr", bus_a.instr,       32'hC0DE_0040);

        // ---- redirect while a request waits for a delayed ack ----
        ack_a = 1'b0;
        tick();
        check_eq("wait_valid", bus_a.instr_valid, 1'b0);
        check_eq("wait_req",   bus_a.rom_req,     1'b1);
        check_eq("wait_addr",  bus_a.rom_addr,    16'h41);

        redir_a = 1'b1; rpc_a = 64'h203;
        tick();
        check_eq("disc_req",   bus_a.rom_req,     1'b1);
        check_eq("disc_addr",  bus_a.rom_addr,    16'h41);
        check_eq("disc_valid", bus_a.instr_valid, 1'b0);

        redir_a = 1'b0;
        tick();
        check_eq("disc_hold_addr", bus_a.rom_addr, 16'h41);

        ack_a = 1'b1;
        tick();
        check_eq("disc_drop_valid", bus_a.instr_valid, 1'b0);
        check_eq("disc_next_req",   bus_a.rom_req,     1'b1);
        check_eq("disc_next_addr",  bus_a.rom_addr,    16'h80);

        tick();
        check_eq("disc_first_valid", bus_a.instr_valid, 1'b1);
        check_eq("disc_first_pc",    bus_a.instr_pc,    64'h200);
        check_eq("disc_first_instr", bus_a.instr,       32'hC0DE_0080);

        // ---- instance B: PC wrap and reset during a request ----
        ack_b = 1'b1; rdy_b = 1'b1;
        reset_b = 1'b0;
        tick();
        check_eq("wrap_req",  bus_b.rom_req,  1'b1);
        check_eq("wrap_addr", bus_b.rom_addr, 6'h3F);

        tick();
        check_eq("wrap_pc_fc",  bus_b.instr_pc,  8'hFC);
        check_eq("wrap_pc4_00", bus_b.instr_pc4, 8'h00);
        check_eq("wrap_instr",  bus_b.instr,     32'h0000_003F);

        tick();
        check_eq("wrap_pc_00",  bus_b.instr_pc,  8'h00);
        check_eq("wrap_pc4_04", bus_b.instr_pc4, 8'h04);

        ack_b = 1'b0; rdy_b = 1'b0;
        tick();
        check_eq("pre_rst_req",   bus_b.rom_req,     1'b1);
        check_eq("pre_rst_valid", bus_b.instr_valid, 1'b1);

        #2 reset_b = 1'b1;
        #1;
        check_eq("async_rst_req",   bus_b.rom_req,     1'b0);
        check_eq("async_rst_valid", bus_b.instr_valid, 1'b0);
        check_eq("async_rst_addr",  bus_b.rom_addr,    6'h3F);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
